// File: rtl/cpu_multiply_pkg.sv
// Shared types and operand-signedness helpers for the RV32M multiply pipeline.
package cpu_multiply_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HSS = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HUU = 2'b11
    } mul_op_t;

    function automatic logic op1_signed(input mul_op_t op);
        return op != MUL_HUU;
    endfunction

    function automatic logic op2_signed(input mul_op_t op);
        return (op == MUL_LO) || (op == MUL_HSS);
    endfunction

    function automatic logic sel_high(input mul_op_t op);
        return op != MUL_LO;
    endfunction

endpackage

// File: rtl/cpu_pipe_stage.sv
// One pipeline slot: valid bit plus data word, loaded together under a shared enable.
module cpu_pipe_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  valid_d,
    input  logic [DATA_WIDTH-1:0] data_d,
    output logic                  valid_q,
    output logic [DATA_WIDTH-1:0] data_q
);

    // Flush overrides the enable so a stalled pipe can still be emptied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= valid_d;
            end
            if (en) begin
                data_q <= data_d;
            end
        end
    end

endmodule

// File: rtl/cpu_multiply_pipe.sv
// Fully pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with tag passthrough,
// global-advance backpressure and flush of in-flight operations.
module cpu_multiply_pipe
    import cpu_multiply_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 3,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  mul_op_t              i_op,
    input  logic [WIDTH-1:0]     i_op1,
    input  logic [WIDTH-1:0]     i_op2,
    input  logic [TAG_WIDTH-1:0] i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_result,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_busy
);

    localparam int EXT_W  = WIDTH + 1;
    localparam int PROD_W = 2 * WIDTH + 2;
    localparam int CTL_W  = 2 + TAG_WIDTH;
    localparam int S1_W   = 2 * EXT_W + CTL_W;
    localparam int MID_W  = PROD_W + CTL_W;
    localparam int OUT_W  = WIDTH + TAG_WIDTH;
    localparam int NCHAIN = STAGES - 1;

    function automatic logic [WIDTH-1:0] select_result(input logic [PROD_W-1:0] p,
                                                       input mul_op_t           op);
        return sel_high(op) ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
    endfunction

    logic adv;
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    // Operand extension: one extra bit makes every RV32M variant a signed multiply.
    logic signed [EXT_W-1:0] op1_ext;
    logic signed [EXT_W-1:0] op2_ext;
    logic [S1_W-1:0]         s1_d;
    logic [S1_W-1:0]         s1_q;
    logic                    s1_vld;

    assign op1_ext = {op1_signed(i_op) & i_op1[WIDTH-1], i_op1};
    assign op2_ext = {op2_signed(i_op) & i_op2[WIDTH-1], i_op2};
    assign s1_d    = {op1_ext, op2_ext, i_op, i_tag};

    cpu_pipe_stage #(.DATA_WIDTH(S1_W)) u_stage_ops (
        .clk     (i_clock),
        .rst     (i_reset),
        .en      (adv),
        .flush   (i_flush),
        .valid_d (i_valid),
        .data_d  (s1_d),
        .valid_q (s1_vld),
        .data_q  (s1_q)
    );

    // Multiply on registered operands; result feeds the product/delay chain.
    logic signed [EXT_W-1:0]  s1_op1;
    logic signed [EXT_W-1:0]  s1_op2;
    logic signed [PROD_W-1:0] mcand;
    logic signed [PROD_W-1:0] mplier;
    logic signed [PROD_W-1:0] prod;

    assign s1_op1 = s1_q[S1_W-1 -: EXT_W];
    assign s1_op2 = s1_q[S1_W-1-EXT_W -: EXT_W];
    assign mcand  = {{(PROD_W-EXT_W){s1_op1[EXT_W-1]}}, s1_op1};
    assign mplier = {{(PROD_W-EXT_W){s1_op2[EXT_W-1]}}, s1_op2};
    assign prod   = mcand * mplier;

    logic [MID_W-1:0] chain_q   [NCHAIN];
    logic             chain_vld [NCHAIN];

    assign chain_q[0]   = {prod, s1_q[CTL_W-1:0]};
    assign chain_vld[0] = s1_vld;

    // Product register and any extra delay stages; empty when STAGES == 2.
    generate
        for (genvar k = 1; k < NCHAIN; k++) begin : g_mid
            cpu_pipe_stage #(.DATA_WIDTH(MID_W)) u_stage_prod (
                .clk     (i_clock),
                .rst     (i_reset),
                .en      (adv),
                .flush   (i_flush),
                .valid_d (chain_vld[k-1]),
                .data_d  (chain_q[k-1]),
                .valid_q (chain_vld[k]),
                .data_q  (chain_q[k])
            );
        end
    endgenerate

    // Output stage: select the requested half of the product.
    logic [MID_W-1:0]     tail;
    logic [PROD_W-1:0]    tail_prod;
    mul_op_t              tail_op;
    logic [TAG_WIDTH-1:0] tail_tag;
    logic [OUT_W-1:0]     out_d;
    logic [OUT_W-1:0]     out_q;

    assign tail      = chain_q[NCHAIN-1];
    assign tail_prod = tail[MID_W-1 -: PROD_W];
    assign tail_op   = mul_op_t'(tail[TAG_WIDTH +: 2]);
    assign tail_tag  = tail[TAG_WIDTH-1:0];
    assign out_d     = {select_result(tail_prod, tail_op), tail_tag};

    cpu_pipe_stage #(.DATA_WIDTH(OUT_W)) u_stage_out (
        .clk     (i_clock),
        .rst     (i_reset),
        .en      (adv),
        .flush   (i_flush),
        .valid_d (chain_vld[NCHAIN-1]),
        .data_d  (out_d),
        .valid_q (o_valid),
        .data_q  (out_q)
    );

    assign o_result = out_q[OUT_W-1 -: WIDTH];
    assign o_tag    = out_q[TAG_WIDTH-1:0];

    always_comb begin
        o_busy = o_valid;
        for (int k = 0; k < NCHAIN; k++) begin
            o_busy = o_busy | chain_vld[k];
        end
    end

endmodule

// File: tb/tb_cpu_multiply_pipe.sv
// Directed bench for cpu_multiply_pipe with an in-order scoreboard of result/tag pairs.
module tb_cpu_multiply_pipe;
    import cpu_multiply_pkg::*;

    localparam int W  = 32;
    localparam int ST = 3;
    localparam int TW = 5;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    mul_op_t       i_op;
    logic [W-1:0]  i_op1;
    logic [W-1:0]  i_op2;
    logic [TW-1:0] i_tag;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_result;
    logic [TW-1:0] o_tag;
    logic          o_busy;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    logic accepted;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_out    = 0;

    cpu_multiply_pipe #(.WIDTH(W), .STAGES(ST), .TAG_WIDTH(TW)) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag),
        .o_busy   (o_busy)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    function automatic logic [W-1:0] model(input mul_op_t op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [65:0] ea, eb, p;
        ea = (op == MUL_HUU) ? {34'd0, a} : {{34{a[31]}}, a};
        eb = (op == MUL_LO || op == MUL_HSS) ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return (op == MUL_LO) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Sample at the falling edge, pop on output handshake, push on input handshake.
    task automatic tick();
        exp_t e;
        @(negedge i_clock);
        chk("ready_rule", o_ready, !o_valid || i_ready);
        if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", o_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("result", o_result, e.res);
                chk("tag", o_tag, e.tag);
                n_out++;
            end
        end
        accepted = 1'b0;
        if (i_flush) begin
            sb.delete();
        end else if (i_valid && o_ready) begin
            sb.push_back(cur_exp);
            accepted = 1'b1;
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic send(input mul_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] res);
        i_valid     = 1'b1;
        i_op        = op;
        i_op1       = a;
        i_op2       = b;
        i_tag       = tag;
        cur_exp.res = res;
        cur_exp.tag = tag;
        for (int g = 0; g < 20; g++) begin
            tick();
            if (accepted) break;
        end
        chk("accepted", accepted, 1);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 20 && sb.size() > 0; g++) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int cnt;
        int idx;
        int cyc;
        int n_out0;
        logic [W-1:0] a, b;
        mul_op_t op;

        i_reset = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_op    = MUL_LO;
        i_op1   = '0;
        i_op2   = '0;
        i_tag   = '0;
        accepted = 1'b0;
        cur_exp  = '0;
        repeat (2) @(posedge i_clock);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_result", o_result, 0);
        chk("rst_tag", o_tag, 0);
        i_reset = 1'b0;
        #1;
        chk("rst_ready", o_ready, 1);

        // Latency of a single MUL
        send(MUL_LO, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
        cnt = 0;
        while (!o_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("latency", cnt, ST - 1);
        drain();

        // Directed high-half cases, back to back
        send(MUL_HSS, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
        send(MUL_HUU, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
        send(MUL_HSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000);
        send(MUL_HSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF);
        send(MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
        drain();

        // Eight random ops with a three-cycle downstream stall mid-stream
        n_out0 = n_out;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 60) begin
            if (!i_valid) begin
                a  = $urandom;
                b  = $urandom;
                op = mul_op_t'($urandom_range(0, 3));
                i_op  = op;
                i_op1 = a;
                i_op2 = b;
                i_tag = TW'(idx);
                cur_exp.res = model(op, a, b);
                cur_exp.tag = TW'(idx);
            end
            i_valid = 1'b1;
            i_ready = !(cyc >= 4 && cyc < 7);
            if (!i_ready) begin
                #1;
                chk("ready_low_stall", o_ready, 0);
            end
            tick();
            if (accepted) begin
                idx++;
                i_valid = 1'b0;
            end
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain();
        chk("stream_count", n_out - n_out0, 8);

        // Flush with two accepted and a third offered in the flush cycle
        send(MUL_LO, 32'd3, 32'd4, 5'd10, 32'd12);
        send(MUL_LO, 32'd5, 32'd6, 5'd11, 32'd30);
        i_valid = 1'b1;
        i_tag   = 5'd12;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_busy", o_busy, 0);
        chk("flush_valid", o_valid, 0);
        repeat (5) tick();
        send(MUL_LO, 32'd9, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFF7);
        drain();

        // Flush while the output is stalled
        i_ready = 1'b0;
        send(MUL_HUU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, model(MUL_HUU, 32'h1234_5678, 32'h9ABC_DEF0));
        for (int g = 0; g < 10 && !o_valid; g++) tick();
        chk("stall_valid_up", o_valid, 1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("stall_flush_valid", o_valid, 0);
        chk("stall_flush_busy", o_busy, 0);
        i_ready = 1'b1;

        // Asynchronous reset with two ops in flight and the output valid
        i_ready = 1'b0;
        send(MUL_LO, 32'd11, 32'd12, 5'd21, 32'd132);
        send(MUL_LO, 32'd13, 32'd14, 5'd22, 32'd182);
        for (int g = 0; g < 10 && !o_valid; g++) tick();
        chk("pre_reset_valid", o_valid, 1);
        #2;
        i_reset = 1'b1;
        #1;
        chk("reset_valid", o_valid, 0);
        chk("reset_result", o_result, 0);
        chk("reset_tag", o_tag, 0);
        chk("reset_busy", o_busy, 0);
        sb.delete();
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        i_ready = 1'b1;
        repeat (6) tick();
        chk("post_reset_ready", o_ready, 1);
        send(MUL_HSU, 32'hFFFF_FFFE, 32'd3, 5'd23, model(MUL_HSU, 32'hFFFF_FFFE, 32'd3));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
